// File: rtl/ble_pkg.sv
// ble_pkg: shared state encoding and CRC-24 constants for the BLE baseband
package ble_pkg;
    typedef enum logic [1:0] {IDLE, PDU, CRC} state_t;
    localparam int CRC_W = 24;
    localparam logic [CRC_W-1:0] BLE_ADV_CRC_INIT = 24'h555555;
    // x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1, x^24 implied
    localparam logic [CRC_W-1:0] CRC_POLY = 24'h00065B;
endpackage

// File: rtl/serial_crc24.sv
// serial_crc24: bit-serial BLE CRC-24 LFSR with synchronous preset
module serial_crc24
    import ble_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             i_restart,
    input  logic [CRC_W-1:0] i_init,
    input  logic             i_tvalid,
    input  logic             i_tdata,
    output logic [CRC_W-1:0] o_crc
);
    logic [CRC_W-1:0] r_crc;
    logic             w_fb;

    assign w_fb  = i_tdata ^ r_crc[CRC_W-1];
    assign o_crc = r_crc;

    // preset while restarting, otherwise shift one bit per accepted input
    always_ff @(posedge aclk)
        if (!aresetn || i_restart) r_crc <= i_init;
        else if (i_tvalid) r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
endmodule

// File: rtl/ble_pdu_serializer.sv
// ble_pdu_serializer: byte stream to LSB-first bit stream with appended CRC-24
module ble_pdu_serializer
    import ble_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [CRC_W-1:0] crc_init,
    input  logic [7:0]       in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic             in_tlast,
    output logic             out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tlast,
    output logic             busy,
    output logic             underrun
);
    state_t           r_state, w_next;
    logic [7:0]       r_byte;
    logic [2:0]       r_bit_cnt;
    logic [4:0]       r_crc_cnt;
    logic             r_last, r_has_byte, r_underrun;
    logic [CRC_W-1:0] w_crc;
    logic             w_in_hs, w_out_hs, w_byte_end;

    assign w_in_hs    = in_tvalid && in_tready;
    assign w_out_hs   = out_tvalid && out_tready;
    assign w_byte_end = (r_state == PDU) && w_out_hs && (r_bit_cnt == 3'd7);
    assign busy       = (r_state != IDLE);
    assign underrun   = r_underrun;

    // next state and stream outputs; the next-byte ready in PDU follows out_tready so refills are gapless
    always_comb begin
        w_next     = r_state;
        in_tready  = 1'b0;
        out_tdata  = 1'b0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        case (r_state)
            IDLE: begin
                in_tready = aresetn;
                if (in_tvalid) w_next = PDU;
            end
            PDU: begin
                out_tdata  = r_byte[r_bit_cnt];
                out_tvalid = r_has_byte;
                in_tready  = !r_last && (!r_has_byte || (r_bit_cnt == 3'd7 && out_tready));
                if (r_has_byte && out_tready && r_bit_cnt == 3'd7 && r_last) w_next = CRC;
            end
            CRC: begin
                out_tdata  = w_crc[5'd23 - r_crc_cnt];
                out_tvalid = 1'b1;
                out_tlast  = (r_crc_cnt == 5'd23);
                if (out_tready && r_crc_cnt == 5'd23) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge aclk)
        if (!aresetn) r_state <= IDLE;
        else r_state <= w_next;

    // byte holding register and bit pointer; a new byte always restarts at bit 0
    always_ff @(posedge aclk)
        if (!aresetn) begin
            r_byte     <= '0;
            r_bit_cnt  <= '0;
            r_last     <= 1'b0;
            r_has_byte <= 1'b0;
        end else if (w_in_hs) begin
            r_byte     <= in_tdata;
            r_bit_cnt  <= '0;
            r_last     <= in_tlast;
            r_has_byte <= 1'b1;
        end else if (r_state == PDU && w_out_hs) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_has_byte <= 1'b0;
        end

    // CRC bit pointer, cleared whenever not sending the CRC
    always_ff @(posedge aclk)
        if (!aresetn || r_state != CRC) r_crc_cnt <= '0;
        else if (w_out_hs) r_crc_cnt <= r_crc_cnt + 5'd1;

    // flag a byte boundary inside the PDU that found no successor byte waiting
    always_ff @(posedge aclk)
        r_underrun <= aresetn && w_byte_end && !r_last && !w_in_hs;

    serial_crc24 u_crc (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_restart (r_state == IDLE),
        .i_init    (crc_init),
        .i_tvalid  ((r_state == PDU) && w_out_hs),
        .i_tdata   (out_tdata),
        .o_crc     (w_crc)
    );
endmodule

// File: tb/tb_ble_pdu_serializer.sv
// tb_ble_pdu_serializer: randomized check of the serializer against a packet-level model
module tb_ble_pdu_serializer;
    import ble_pkg::*;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [23:0] crc_init = '0;
    logic [7:0]  in_tdata = '0;
    logic        in_tvalid = 1'b0, in_tlast = 1'b0, out_tready = 1'b1;
    logic        in_tready, out_tdata, out_tvalid, out_tlast, busy, underrun;

    int          errors = 0, checks = 0;
    bit          exp_q[$], expl_q[$];
    int          rdy_mode = 0;
    int          hs_cnt = 0, gap_cnt = 0, und_cnt = 0;
    logic [63:0] got_all = '0;
    logic        prev_stall = 1'b0, prev_data = 1'b0, prev_last = 1'b0, prev_in_hs = 1'b0;

    ble_pdu_serializer dut (
        .aclk(aclk), .aresetn(aresetn), .crc_init(crc_init),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .busy(busy), .underrun(underrun)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC as polynomial division of the message bits (in transmit order) seeded with init
    function automatic logic [23:0] crc_model(input logic [23:0] init, input logic [7:0] b[$]);
        int          ex[7] = '{10, 9, 6, 4, 3, 1, 0};
        logic [23:0] poly = '0;
        logic [23:0] c = init;
        bit          top;
        foreach (ex[k]) poly[ex[k]] = 1'b1;
        foreach (b[i])
            for (int j = 0; j < 8; j++) begin
                top = c[23] ^ b[i][j];
                c = c << 1;
                if (top) c = c ^ poly;
            end
        return c;
    endfunction

    // expected stream: bytes LSB-first, then CRC MSB-first, tlast on the very last bit
    task automatic push_model(input logic [23:0] init, input logic [7:0] b[$]);
        logic [23:0] c = crc_model(init, b);
        foreach (b[i])
            for (int j = 0; j < 8; j++) begin
                exp_q.push_back(b[i][j]);
                expl_q.push_back(1'b0);
            end
        for (int k = 23; k >= 0; k--) begin
            exp_q.push_back(c[k]);
            expl_q.push_back(k == 0);
        end
    endtask

    always @(posedge aclk) begin
        #1 out_tready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // compare process: every output handshake against the model, plus hold and latency rules
    always @(negedge aclk) begin
        bit d, l;
        if (!aresetn) begin
            chk("reset_in_tready", in_tready, 0);
            prev_stall = 1'b0;
            prev_in_hs = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {out_tvalid, out_tdata, out_tlast}, {1'b1, prev_data, prev_last});
            if (prev_in_hs) chk("latency", out_tvalid, 1);
            if (busy && !out_tvalid) gap_cnt++;
            if (underrun) und_cnt++;
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_bit: got bit %0d with no expected bit", out_tdata);
                end else begin
                    d = exp_q.pop_front();
                    l = expl_q.pop_front();
                    chk("bit", {out_tdata, out_tlast}, {d, l});
                end
                hs_cnt++;
                got_all = {got_all[62:0], out_tdata};
            end
            prev_stall = out_tvalid && !out_tready;
            prev_data  = out_tdata;
            prev_last  = out_tlast;
            prev_in_hs = in_tvalid && in_tready;
        end
    end

    // offer the packet's bytes; byte hold_idx is withheld until hold_cyc cycles after the underrun starts
    task automatic send(input logic [7:0] b[$], input int hold_idx, input int hold_cyc);
        bit ok;
        int t;
        push_model(crc_init, b);
        hs_cnt  = 0;
        gap_cnt = 0;
        und_cnt = 0;
        foreach (b[i]) begin
            if (i == hold_idx) begin
                in_tvalid = 1'b0;
                t = 0;
                while (!underrun && t < 100) begin
                    @(posedge aclk) #1;
                    t++;
                end
                repeat (hold_cyc - 1) @(posedge aclk) #1;
            end
            in_tvalid = 1'b1;
            in_tdata  = b[i];
            in_tlast  = (i == b.size() - 1);
            t = 0;
            do begin
                @(negedge aclk);
                ok = in_tready;
                @(posedge aclk) #1;
                t++;
            end while (!ok && t < 400);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: byte %0d not accepted", i);
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while ((exp_q.size() != 0 || busy) && t < 4000);
        if (t >= 4000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d bits still expected", exp_q.size());
        end
        @(posedge aclk) #1;
    endtask

    initial begin
        logic [7:0]  pk[$];
        logic [23:0] c_gapless, c_stall;
        int          t;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_in_tready", in_tready, 1);
        chk("rst_outs", {out_tvalid, out_tdata, out_tlast, busy, underrun}, 0);
        @(posedge aclk) #1;

        crc_init = 24'h0;
        pk = '{8'h01};
        chk("model_pin", crc_model(24'h0, pk), 24'h032D80);
        send(pk, -1, 0);
        wait_done();
        chk("crc_01", got_all[23:0], 24'h032D80);
        chk("pdu_01", got_all[31:24], 8'h80);
        chk("len_01", hs_cnt, 32);

        pk = '{8'h00};
        send(pk, -1, 0);
        wait_done();
        chk("all_zero", got_all[31:0], 0);
        chk("len_00", hs_cnt, 32);

        crc_init = BLE_ADV_CRC_INIT;
        pk = '{8'hA5, 8'h3C};
        send(pk, -1, 0);
        wait_done();
        chk("pdu_a53c", got_all[39:24], 16'hA53C);
        chk("gapless", gap_cnt, 0);
        chk("no_underrun", und_cnt, 0);
        chk("len_a53c", hs_cnt, 40);
        c_gapless = got_all[23:0];

        send(pk, 1, 5);
        wait_done();
        chk("underrun_once", und_cnt, 1);
        chk("gap_5", gap_cnt, 5);
        chk("crc_same_late", got_all[23:0], c_gapless);

        crc_init = 24'($urandom);
        pk = {};
        for (int i = 0; i < 10; i++) pk.push_back(8'($urandom));
        rdy_mode = 1;
        send(pk, -1, 0);
        wait_done();
        rdy_mode = 0;
        chk("len_10_stall", hs_cnt, 104);
        c_stall = got_all[23:0];
        send(pk, -1, 0);
        wait_done();
        chk("crc_stall_eq", got_all[23:0], c_stall);
        chk("gapless_10", gap_cnt, 0);

        crc_init = 24'($urandom);
        pk = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send(pk, -1, 0);
        t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (hs_cnt < 34 && t < 500);
        chk("reach_crc10", hs_cnt >= 34, 1);
        @(posedge aclk) #1;
        aresetn = 1'b0;
        exp_q.delete();
        expl_q.delete();
        @(posedge aclk) #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_rst_idle", {busy, in_tready, out_tvalid, out_tlast, underrun}, 5'b01000);
        @(posedge aclk) #1;
        crc_init = 24'($urandom);
        pk = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        send(pk, -1, 0);
        wait_done();
        chk("crc_after_rst", got_all[23:0], crc_model(crc_init, pk));
        chk("len_after_rst", hs_cnt, 56);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ble_pdu_serializer.md
# ble_pdu_serializer

Byte-to-bit serializer for the BLE transmit baseband. Accepts a PDU (header + payload) as an AXI-Stream byte stream, emits it LSB-first as a 1-bit AXI-Stream, and appends the 24-bit CRC computed over the emitted PDU bits. It sits directly upstream of the bit-level whitening and modulator path and owns the CRC-24 LFSR instance.

## Interface
- Parameters: none; CRC polynomial and width are fixed by BLE.
- aclk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- crc_init  in  24  CRC preset; sampled on the cycle the first PDU byte is accepted.
- in_tdata  in  8  PDU byte.
- in_tvalid  in  1  byte valid.
- in_tready  out  1  byte accepted when in_tvalid & in_tready.
- in_tlast  in  1  marks the last PDU byte.
- out_tdata  out  1  serial bit: PDU LSB-first, then CRC.
- out_tvalid  out  1  bit valid.
- out_tready  in  1  downstream accepts bit.
- out_tlast  out  1  high with the final CRC bit.
- busy  out  1  high in states PDU and CRC.
- underrun  out  1  one-cycle pulse when a mid-packet byte is not available in time.

## Operation
- States: IDLE, PDU, CRC. Reset state is IDLE.
- IDLE: in_tready=1 and CRC LFSR held at crc_init (restart asserted). On byte handshake: load byte register, bit_cnt=0, latch last flag from in_tlast, go to PDU.
- PDU: out_tdata = byte_reg[bit_cnt]; out_tvalid = has_byte. Each out handshake advances the LFSR with that bit and increments bit_cnt.
- End of byte (out handshake at bit_cnt=7):
  - If last flag is set: go to CRC with crc_cnt=0. in_tready stays low.
  - Otherwise: in_tready=1 in that same cycle. It is combinational from out_tready and is the only such path. A new byte accepted then gives gapless output.
  - If no byte arrives: has_byte clears, out_tvalid drops, underrun pulses once, and the block waits in PDU for the next byte. A late byte restarts output at bit 0.
- CRC: out_tdata = crc_out[23-crc_cnt], so CRC bit 23 goes first. The LFSR is frozen (in_tvalid to the CRC instance is 0). crc_cnt increments per handshake. out_tlast=1 at crc_cnt=23, and its handshake returns the block to IDLE.
- in_tlast on the first byte is legal and gives an 8-bit PDU plus 24 CRC bits.
- No length check is performed; the PDU length is defined solely by in_tlast.

## Timing
- Reset values: in_tready=0 while aresetn=0, then 1 (IDLE); out_tdata=0, out_tvalid=0, out_tlast=0, busy=0, underrun=0.
- Latency: a byte accepted at edge N presents bit 0 at cycle N+1.
- Throughput: 1 bit/cycle with out_tready high and bytes offered on time. A packet of B bytes takes 8B+24 output cycles.
- First CRC bit: valid the cycle after the handshake of the last PDU bit. There is no bubble, because the LFSR updates on that same edge.
- Back-to-back packets: the last CRC handshake returns to IDLE. The next byte is accepted one cycle later at the earliest, giving one idle cycle between packets.
- out_tdata, out_tvalid and out_tlast are stable while out_tvalid & ~out_tready (AXI-Stream hold rule).
- Reset mid-packet: the next cycle is IDLE with all outputs at reset values. The partial packet is discarded and the LFSR reloads crc_init.

## Structure
- Shared package ble_pkg: state enum {IDLE, PDU, CRC}, CRC_W=24, BLE_ADV_CRC_INIT=24'h555555.
- Sub-module: instantiate serial_crc24, with:
  - restart = (state==IDLE)
  - in_tvalid = PDU bit handshake
  - in_tdata = current bit
- No other hierarchy.

## Test plan
- crc_init=0, one byte 0x01 with tlast. Output must be bits 1,0,0,0,0,0,0,0 then CRC 0x032D80 sent MSB-first (0,0,0,0,0,0,1,1,0,0,1,0,1,1,0,1,1,0,0,0,0,0,0,0); out_tlast on bit 32 only.
- crc_init=0, byte 0x00 with tlast. Output must be 32 zero bits, tlast on the 32nd.
- Two bytes 0xA5,0x3C with out_tready held high and the second byte offered on time. Output must be 16 contiguous bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with no out_tvalid gap, then 24 CRC bits matching a bit-serial reference model with crc_init=0x555555.
- Withhold the second byte for 5 cycles after bit 7. Expect: underrun pulses once, out_tvalid low 5 cycles, and the CRC is unchanged versus the gapless run.
- Random out_tready backpressure (50%) on a 10-byte PDU. Bit sequence and CRC must be identical to the no-backpressure run; outputs are held stable during stalls.
- Assert aresetn=0 for 1 cycle during CRC bit 10. Next cycle: IDLE, busy=0, in_tready=1. A following packet produces the correct CRC from the new crc_init.
